// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity codes,
// FSM state encoding and elaboration-time helper functions.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_div.sv
// Bit-period counter: counts 0..DIV-1, emits a one-cycle tick on the last
// count and restarts from 0 on each tick or on an explicit restart.
module uart_baud_div #(
  parameter int DIV = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 2) ? uart_pkg::clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(DIV - 1));

  // Free-running count, reloaded on restart or at the end of a bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO in front of a start/data/parity/stop
// serialiser. Frames leave back-to-back while the FIFO holds words.
//
// Input handshake: a word transfers on a rising clk edge where
// s_valid && s_ready; s_ready depends only on FIFO occupancy (not on
// s_valid), and s_data must be stable while s_valid is high.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 24000000,
  parameter int BAUD       = 1000000,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [1:0]                           cfg_parity,
  input  logic                                 cfg_stop2,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [DATA_BITS-1:0]                 s_data,
  output logic                                 tx,
  output logic                                 busy,
  output logic [uart_pkg::clog2(FIFO_DEPTH):0] fifo_level,
  output state_t                               dbg_state
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int AW  = clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int IW  = clog2(DATA_BITS);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: DIV must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [LW-1:0]        wptr_q, rptr_q;
  logic                 empty, full, push, pop;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [IW-1:0]        bit_idx_q;
  logic                 par_en_q, par_bit_q, stop2_q, stop_cnt_q;
  logic                 tick, tx_d;

  assign fifo_level = wptr_q - rptr_q;
  assign empty      = (wptr_q == rptr_q);
  assign full       = (fifo_level == LW'(FIFO_DEPTH));
  assign s_ready    = !full;
  assign push       = s_valid && s_ready;
  assign dbg_state  = state_q;

  uart_baud_div #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (pop),
    .tick    (tick)
  );

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= s_data;
  end

  // FIFO pointers, one bit wider than the index to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Next-state, pop decision and next line level.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        tx_d = shift_q[0];
        if (tick && bit_idx_q == IW'(DATA_BITS - 1)) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        tx_d = par_bit_q;
        if (tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick) begin
          if (stop2_q && !stop_cnt_q) begin
            state_d = ST_STOP;
          end else if (!empty) begin
            pop     = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, line and busy registers; reset forces the line idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      tx      <= tx_d;
      busy    <= (state_q != ST_IDLE) || !empty;
    end
  end

  // Frame datapath: load word and frame config on pop, shift on data ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      bit_idx_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
    end else if (pop) begin
      shift_q    <= mem[rptr_q[AW-1:0]];
      bit_idx_q  <= '0;
      par_en_q   <= (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
      par_bit_q  <= (cfg_parity == PAR_ODD) ? ~(^mem[rptr_q[AW-1:0]])
                                            :  (^mem[rptr_q[AW-1:0]]);
      stop2_q    <= cfg_stop2;
      stop_cnt_q <= 1'b0;
    end else if (tick) begin
      if (state_q == ST_DATA) begin
        shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
        bit_idx_q <= bit_idx_q + 1'b1;
      end
      if (state_q == ST_STOP) stop_cnt_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8-bit and a 7-bit instance, frames
// sampled mid-bit and compared against hand-computed line patterns.
module tb_uart_tx_fifo;

  localparam int DIV = 24;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_stop2 = 1'b0;
  logic       s_valid = 1'b0, s_valid7 = 1'b0;
  logic [7:0] s_data = '0;
  logic [6:0] s_data7 = '0;
  logic       s_ready, s_ready7, tx, tx7, busy, busy7;
  logic [2:0] fifo_level, fifo_level7;
  uart_pkg::state_t dbg_state, dbg_state7;

  uart_tx_fifo #(.CLK_FREQ(24000000), .BAUD(1000000), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .tx(tx), .busy(busy),
    .fifo_level(fifo_level), .dbg_state(dbg_state)
  );

  uart_tx_fifo #(.CLK_FREQ(24000000), .BAUD(1000000), .DATA_BITS(7), .FIFO_DEPTH(4)) dut7 (
    .clk(clk), .rst_n(rst_n), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .s_valid(s_valid7), .s_ready(s_ready7), .s_data(s_data7), .tx(tx7), .busy(busy7),
    .fifo_level(fifo_level7), .dbg_state(dbg_state7)
  );

  // Scoreboard
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  int t_fall0 = 0;
  int t_acc5 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drivers / monitors
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic get_tx(input bit sel);
    return sel ? tx7 : tx;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? busy7 : busy;
  endfunction

  task automatic push(input bit sel, input string tag, input logic [7:0] d, output int t_acc);
    if (sel) begin
      check({tag, "_ready"}, {31'd0, s_ready7}, 1);
      s_valid7 = 1'b1;
      s_data7  = d[6:0];
    end else begin
      check({tag, "_ready"}, {31'd0, s_ready}, 1);
      s_valid = 1'b1;
      s_data  = d;
    end
    @(posedge clk);
    #1;
    t_acc    = cyc;
    s_valid  = 1'b0;
    s_valid7 = 1'b0;
  endtask

  task automatic wait_fall(input bit sel, input int bound, input string tag, output int t);
    logic found;
    found = 1'b0;
    t = 0;
    for (int i = 0; i < bound && !found; i++) begin
      if (get_tx(sel) == 1'b0) begin
        found = 1'b1;
        t = cyc;
      end else begin
        cycles(1);
      end
    end
    check({tag, "_start_seen"}, {31'd0, found}, 1);
  endtask

  task automatic wait_idle(input bit sel, input int bound, input string tag, output int t);
    logic found;
    found = 1'b0;
    t = 0;
    for (int i = 0; i < bound && !found; i++) begin
      if (get_busy(sel) == 1'b0) begin
        found = 1'b1;
        t = cyc;
      end else begin
        cycles(1);
      end
    end
    check({tag, "_idle_seen"}, {31'd0, found}, 1);
  endtask

  // Entered on the sample where the start bit first shows; samples mid-bit.
  task automatic rx_frame(input bit sel, input int len, output logic [15:0] v);
    v = '0;
    cycles(DIV / 2);
    v[0] = get_tx(sel);
    for (int i = 1; i < len; i++) begin
      cycles(DIV);
      v[i] = get_tx(sel);
    end
  endtask

  task automatic single(input bit sel, input string tag, input logic [7:0] d,
                        input logic [1:0] par, input logic stop2, input int len,
                        input logic [15:0] exp_vec, input int exp_clk);
    int ta, tf, ti;
    logic [15:0] v;
    cfg_parity = par;
    cfg_stop2  = stop2;
    push(sel, tag, d, ta);
    wait_fall(sel, 10, tag, tf);
    check({tag, "_latency"}, tf - ta, 2);
    cfg_parity = ~par;
    cfg_stop2  = ~stop2;
    rx_frame(sel, len, v);
    check({tag, "_bits"}, {16'd0, v}, {16'd0, exp_vec});
    wait_idle(sel, 400, tag, ti);
    check({tag, "_frame_clocks"}, ti - tf, exp_clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, lows;
    logic [15:0] v;
    logic [7:0] words[6];
    words = '{8'h11, 8'h22, 8'h3C, 8'h81, 8'hFF, 8'h00};

    // Reset state
    cycles(3);
    check("rst_tx", {31'd0, tx}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {31'd0, s_ready}, 1);
    check("rst_level", {29'd0, fifo_level}, 0);
    rst_n = 1'b1;
    cycles(2);
    check("post_rst_tx", {31'd0, tx}, 1);
    check("post_rst_state", {29'd0, dbg_state}, {29'd0, uart_pkg::ST_IDLE});

    // Single frames: line pattern bit i = i-th bit period, start first
    single(0, "a5_8n1",   8'hA5, 2'b00, 1'b0, 10, 16'h034A, 240);
    single(0, "07_even",  8'h07, 2'b01, 1'b0, 11, 16'h060E, 264);
    single(0, "07_odd",   8'h07, 2'b10, 1'b0, 11, 16'h040E, 264);
    single(0, "07_par11", 8'h07, 2'b11, 1'b0, 10, 16'h020E, 240);
    single(0, "00_stop2", 8'h00, 2'b00, 1'b1, 11, 16'h0600, 264);
    single(1, "55_d7odd", 8'h55, 2'b10, 1'b0, 10, 16'h03AA, 240);

    // Six words back-to-back into a depth-4 FIFO
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    exp_q = '{16'h0222, 16'h0244, 16'h0278, 16'h0302, 16'h03FE, 16'h0200};
    fork
      begin : pusher
        for (int k = 0; k < 6; k++) begin
          logic acc, rdy;
          acc = 1'b0;
          s_valid = 1'b1;
          s_data  = words[k];
          for (int i = 0; i < 400 && !acc; i++) begin
            rdy = s_ready;
            cycles(1);
            if (rdy) acc = 1'b1;
          end
          check($sformatf("fifo_accept_%0d", k), {31'd0, acc}, 1);
          if (k == 1) check("fifo_level_pushpop", {29'd0, fifo_level}, 1);
          if (k == 4) begin
            check("fifo_level_full", {29'd0, fifo_level}, 4);
            check("fifo_ready_full", {31'd0, s_ready}, 0);
          end
          if (k == 5) t_acc5 = cyc;
        end
        s_valid = 1'b0;
      end
      begin : receiver
        int tf, tprev;
        wait_fall(0, 20, "fifo0", tf);
        t_fall0 = tf;
        for (int f = 0; f < 6; f++) begin
          if (f > 0) begin
            tprev = tf;
            wait_fall(0, 40, $sformatf("fifo%0d", f), tf);
            check($sformatf("fifo%0d_gap", f), tf - tprev, 240);
          end
          rx_frame(0, 10, v);
          check($sformatf("fifo%0d_bits", f), {16'd0, v}, {16'd0, exp_q.pop_front()});
        end
      end
    join
    check("fifo_6th_accept_time", t_acc5 - t_fall0, 240);
    wait_idle(0, 100, "fifo_end", t);
    check("fifo_end_level", {29'd0, fifo_level}, 0);

    // Reset in the middle of a frame with words still queued
    push(0, "mid_w0", 8'hF0, t);
    push(0, "mid_w1", 8'h0F, t);
    push(0, "mid_w2", 8'h33, t);
    wait_fall(0, 10, "mid", t);
    cycles(30);
    check("mid_tx_before", {31'd0, tx}, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", {31'd0, tx}, 1);
    check("mid_rst_level", {29'd0, fifo_level}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    cycles(2);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      cycles(1);
      if (tx == 1'b0) lows++;
    end
    check("mid_no_restart", lows, 0);
    check("mid_post_busy", {31'd0, busy}, 0);
    check("mid_post_ready", {31'd0, s_ready}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
